mem_wb_writeback: RTL and testbench

- Consumer end of the Memory stage interface. Accepts the Memory stage outputs: RegWrite, ALU result, load data, MemtoReg and destination register.
- Registers them in the MEM/WB pipeline register and selects the writeback value.
- Drives the register-file write port.
- Keeps one extra cycle of write history (WB/END) so Execute-stage forwarding can resolve hazards from both retiring instructions.

---
 rtl/mem_wb_writeback_if.sv | 53 +++++
 rtl/mem_wb_writeback.sv | 128 ++++++++++++
 tb/tb_mem_wb_writeback.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/mem_wb_writeback_if.sv
// rtl/mem_wb_writeback_if.sv - Memory-stage to writeback bus: MEM/WB inputs, register-file write port, WB/END history
//
// Purpose : bundles the Memory stage outputs that feed MEM/WB, the register-file
//           write port and the WB/END forwarding history into one interface.
// Modports: master - Memory stage side (drives stage controls and payload, observes outputs)
//           slave  - mem_wb_writeback side
// Signals : Stall, Flush, Valid_In, RegWrite_In, MemtoReg_In, ALUResult_In,
//           ReadData_In, RegDestAddress_In (to writeback);
//           RegWrite_Out, WriteRegister, WriteData, Fwd2_RegWrite, Fwd2_Addr,
//           Fwd2_Data, RetireCount (from writeback; RetireCount only with RETIRE_CNT_EN)
interface mem_wb_writeback_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              Stall;
    logic              Flush;
    logic              Valid_In;
    logic              RegWrite_In;
    logic              MemtoReg_In;
    logic [DATA_W-1:0] ALUResult_In;
    logic [DATA_W-1:0] ReadData_In;
    logic [ADDR_W-1:0] RegDestAddress_In;

    logic              RegWrite_Out;
    logic [ADDR_W-1:0] WriteRegister;
    logic [DATA_W-1:0] WriteData;
    logic              Fwd2_RegWrite;
    logic [ADDR_W-1:0] Fwd2_Addr;
    logic [DATA_W-1:0] Fwd2_Data;
`ifdef RETIRE_CNT_EN
    logic [31:0]       RetireCount;
`endif

    modport master (
        output Stall, Flush, Valid_In, RegWrite_In, MemtoReg_In,
               ALUResult_In, ReadData_In, RegDestAddress_In,
        input  RegWrite_Out, WriteRegister, WriteData,
               Fwd2_RegWrite, Fwd2_Addr, Fwd2_Data
`ifdef RETIRE_CNT_EN
        , input RetireCount
`endif
    );

    modport slave (
        input  Stall, Flush, Valid_In, RegWrite_In, MemtoReg_In,
               ALUResult_In, ReadData_In, RegDestAddress_In,
        output RegWrite_Out, WriteRegister, WriteData,
               Fwd2_RegWrite, Fwd2_Addr, Fwd2_Data
`ifdef RETIRE_CNT_EN
        , output RetireCount
`endif
    );
endinterface

// File: rtl/mem_wb_writeback.sv
// rtl/mem_wb_writeback.sv - MEM/WB pipeline register, writeback mux and WB/END forwarding history
//
// Purpose : captures Memory stage results, selects the writeback value, drives the
//           register-file write port exactly once per instruction, and keeps the
//           previous cycle's write (WB/END) for Execute-stage forwarding.
// Ports   : Clk  - clock, rising edge
//           Rst  - synchronous active-high reset (priority over Flush and Stall)
//           bus  - mem_wb_writeback_if.slave (see interface header)
// Option  : RETIRE_CNT_EN - builds the 32-bit committed-instruction counter (bus.RetireCount)
module mem_wb_writeback #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              Clk,
    input  logic              Rst,
    mem_wb_writeback_if.slave bus
);

    // MEM/WB pipeline register
    logic              valid_q,     valid_d;
    logic              regwrite_q,  regwrite_d;
    logic              memtoreg_q,  memtoreg_d;
    logic [DATA_W-1:0] aluresult_q, aluresult_d;
    logic [DATA_W-1:0] readdata_q,  readdata_d;
    logic [ADDR_W-1:0] dest_q,      dest_d;
    // Set once a held instruction has had its commit cycle
    logic              committed_q, committed_d;

    // WB/END history
    logic              f2_we_q,   f2_we_d;
    logic [ADDR_W-1:0] f2_addr_q, f2_addr_d;
    logic [DATA_W-1:0] f2_data_q, f2_data_d;

    logic              wb_we;
    logic [DATA_W-1:0] wb_data;

    assign wb_data = memtoreg_q ? readdata_q : aluresult_q;
    // ~Rst drops any in-flight write during the reset cycle itself
    assign wb_we   = regwrite_q & valid_q & (dest_q != '0) & ~committed_q & ~Rst;

    assign bus.RegWrite_Out  = wb_we;
    assign bus.WriteRegister = dest_q;
    assign bus.WriteData     = wb_data;
    assign bus.Fwd2_RegWrite = f2_we_q;
    assign bus.Fwd2_Addr     = f2_addr_q;
    assign bus.Fwd2_Data     = f2_data_q;

    always_comb begin
        valid_d     = valid_q;
        regwrite_d  = regwrite_q;
        memtoreg_d  = memtoreg_q;
        aluresult_d = aluresult_q;
        readdata_d  = readdata_q;
        dest_d      = dest_q;
        committed_d = committed_q;

        if (bus.Flush) begin
            valid_d     = 1'b0;
            regwrite_d  = 1'b0;
            memtoreg_d  = 1'b0;
            aluresult_d = '0;
            readdata_d  = '0;
            dest_d      = '0;
            committed_d = 1'b0;
        end else if (bus.Stall) begin
            // A held real instruction has committed after its first cycle here
            committed_d = committed_q | valid_q;
        end else begin
            valid_d     = bus.Valid_In;
            regwrite_d  = bus.RegWrite_In & bus.Valid_In;
            memtoreg_d  = bus.MemtoReg_In;
            aluresult_d = bus.ALUResult_In;
            readdata_d  = bus.ReadData_In;
            dest_d      = bus.RegDestAddress_In;
            committed_d = 1'b0;
        end

        // Masked and bubble cycles keep the last real write's address/data
        f2_we_d   = wb_we;
        f2_addr_d = wb_we ? dest_q  : f2_addr_q;
        f2_data_d = wb_we ? wb_data : f2_data_q;
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            valid_q     <= 1'b0;
            regwrite_q  <= 1'b0;
            memtoreg_q  <= 1'b0;
            aluresult_q <= '0;
            readdata_q  <= '0;
            dest_q      <= '0;
            committed_q <= 1'b0;
            f2_we_q     <= 1'b0;
            f2_addr_q   <= '0;
            f2_data_q   <= '0;
        end else begin
            valid_q     <= valid_d;
            regwrite_q  <= regwrite_d;
            memtoreg_q  <= memtoreg_d;
            aluresult_q <= aluresult_d;
            readdata_q  <= readdata_d;
            dest_q      <= dest_d;
            committed_q <= committed_d;
            f2_we_q     <= f2_we_d;
            f2_addr_q   <= f2_addr_d;
            f2_data_q   <= f2_data_d;
        end
    end

`ifdef RETIRE_CNT_EN
    // Counts every real instruction once, whether or not it writes a register
    logic        retire_now;
    logic [31:0] retire_cnt_q, retire_cnt_d;

    assign retire_now      = valid_q & ~committed_q;
    assign retire_cnt_d    = retire_now ? retire_cnt_q + 32'd1 : retire_cnt_q;
    assign bus.RetireCount = retire_cnt_q;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            retire_cnt_q <= '0;
        end else begin
            retire_cnt_q <= retire_cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_mem_wb_writeback.sv
// tb/tb_mem_wb_writeback.sv - self-checking bench for mem_wb_writeback (directed table plus random vs reference model)
module tb_mem_wb_writeback;

    logic Clk = 1'b0;
    logic Rst;

    always #5 Clk = ~Clk;

    mem_wb_writeback_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    mem_wb_writeback #(.DATA_W(32), .ADDR_W(5)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference model: the instruction currently in writeback and how many
    // cycles it has been held (only cycle 0 of a hold may commit).
    logic        m_valid, m_we, m_m2r;
    logic [31:0] m_alu, m_rd;
    logic [4:0]  m_dest;
    int          m_age;
    logic        m_f2we;
    logic [4:0]  m_f2a;
    logic [31:0] m_f2d;
    logic [31:0] m_rc;

    function automatic logic m_commit_write();
        return m_valid && m_we && (m_dest != 5'd0) && (m_age == 0);
    endfunction

    task automatic model_edge(input logic r, s, f, v, rw, m2r,
                              input logic [31:0] alu, rd, input logic [4:0] dest);
        if (r) begin
            m_valid = 0; m_we = 0; m_m2r = 0; m_alu = 0; m_rd = 0; m_dest = 0; m_age = 0;
            m_f2we = 0; m_f2a = 0; m_f2d = 0; m_rc = 0;
        end else begin
            m_f2we = m_commit_write();
            if (m_f2we) begin
                m_f2a = m_dest;
                m_f2d = m_m2r ? m_rd : m_alu;
            end
            if (m_valid && m_age == 0) m_rc = m_rc + 32'd1;
            if (f) begin
                m_valid = 0; m_we = 0; m_m2r = 0; m_alu = 0; m_rd = 0; m_dest = 0; m_age = 0;
            end else if (s) begin
                m_age = (m_age < 2) ? m_age + 1 : 2;
            end else begin
                m_valid = v; m_we = v & rw; m_m2r = m2r; m_alu = alu; m_rd = rd; m_dest = dest; m_age = 0;
            end
        end
    endtask

    // One clock: drive at negedge, advance model, observe 1 time unit after the edge
    task automatic step(input logic r, s, f, v, rw, m2r,
                        input logic [31:0] alu, rd, input logic [4:0] dest);
        @(negedge Clk);
        Rst                   = r;
        bus.Stall             = s;
        bus.Flush             = f;
        bus.Valid_In          = v;
        bus.RegWrite_In       = rw;
        bus.MemtoReg_In       = m2r;
        bus.ALUResult_In      = alu;
        bus.ReadData_In       = rd;
        bus.RegDestAddress_In = dest;
        model_edge(r, s, f, v, rw, m2r, alu, rd, dest);
        @(posedge Clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".we"},   {31'd0, bus.RegWrite_Out}, {31'd0, m_commit_write() & ~Rst});
        chk({tag, ".wa"},   {27'd0, bus.WriteRegister}, {27'd0, m_dest});
        chk({tag, ".wd"},   bus.WriteData, m_m2r ? m_rd : m_alu);
        chk({tag, ".f2we"}, {31'd0, bus.Fwd2_RegWrite}, {31'd0, m_f2we});
        chk({tag, ".f2a"},  {27'd0, bus.Fwd2_Addr}, {27'd0, m_f2a});
        chk({tag, ".f2d"},  bus.Fwd2_Data, m_f2d);
`ifdef RETIRE_CNT_EN
        chk({tag, ".rc"},   bus.RetireCount, m_rc);
`endif
    endtask

    typedef struct {
        logic        r, s, f, v, rw, m2r;
        logic [31:0] alu, rd;
        logic [4:0]  dest;
        logic        e_we;
        logic [4:0]  e_wa;
        logic [31:0] e_wd;
        logic        e_f2we;
        logic [4:0]  e_f2a;
        logic [31:0] e_f2d;
        logic [31:0] e_rc;
    } vec_t;

    vec_t tbl [16];

    initial begin
        //          r  s  f  v  rw m2r alu           rd            dest   we wa  wd            f2we f2a f2d          rc
        tbl[0]  = '{1, 0, 0, 0, 0, 0, 32'h0,        32'h0,        5'd0,  0, 0,  32'h0,        0, 0,  32'h0,        0};
        tbl[1]  = '{1, 0, 0, 0, 0, 0, 32'h0,        32'h0,        5'd0,  0, 0,  32'h0,        0, 0,  32'h0,        0};
        tbl[2]  = '{0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        5'd0,  0, 0,  32'h0,        0, 0,  32'h0,        0};
        tbl[3]  = '{0, 0, 0, 1, 1, 0, 32'h1,        32'h0,        5'd16, 1, 16, 32'h1,        0, 0,  32'h0,        0};
        tbl[4]  = '{0, 0, 0, 1, 1, 1, 32'h10,       32'hDEADBEEF, 5'd8,  1, 8,  32'hDEADBEEF, 1, 16, 32'h1,        1};
        tbl[5]  = '{0, 0, 0, 1, 1, 0, 32'h55,       32'h0,        5'd0,  0, 0,  32'h55,       1, 8,  32'hDEADBEEF, 2};
        tbl[6]  = '{0, 0, 0, 1, 1, 0, 32'h33,       32'h0,        5'd3,  1, 3,  32'h33,       0, 8,  32'hDEADBEEF, 3};
        tbl[7]  = '{0, 1, 0, 1, 1, 0, 32'h99,       32'h0,        5'd9,  0, 3,  32'h33,       1, 3,  32'h33,       4};
        tbl[8]  = '{0, 1, 0, 1, 1, 0, 32'h99,       32'h0,        5'd9,  0, 3,  32'h33,       0, 3,  32'h33,       4};
        tbl[9]  = '{0, 1, 0, 1, 1, 0, 32'h99,       32'h0,        5'd9,  0, 3,  32'h33,       0, 3,  32'h33,       4};
        tbl[10] = '{0, 1, 1, 1, 1, 0, 32'h99,       32'h0,        5'd9,  0, 0,  32'h0,        0, 3,  32'h33,       4};
        tbl[11] = '{0, 0, 0, 1, 1, 0, 32'h77,       32'h0,        5'd5,  1, 5,  32'h77,       0, 3,  32'h33,       4};
        tbl[12] = '{1, 0, 0, 1, 1, 0, 32'h66,       32'h0,        5'd6,  0, 0,  32'h0,        0, 0,  32'h0,        0};
        tbl[13] = '{0, 0, 0, 1, 1, 0, 32'h66,       32'h0,        5'd6,  1, 6,  32'h66,       0, 0,  32'h0,        0};
        tbl[14] = '{0, 0, 1, 1, 1, 0, 32'h12,       32'h0,        5'd2,  0, 0,  32'h0,        1, 6,  32'h66,       1};
        tbl[15] = '{0, 0, 0, 0, 1, 0, 32'h70,       32'h0,        5'd7,  0, 7,  32'h70,       0, 6,  32'h66,       1};

        Rst = 1'b1;
        bus.Stall = 0; bus.Flush = 0; bus.Valid_In = 0; bus.RegWrite_In = 0;
        bus.MemtoReg_In = 0; bus.ALUResult_In = 0; bus.ReadData_In = 0; bus.RegDestAddress_In = 0;
        model_edge(1, 0, 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 16; i++) begin
            step(tbl[i].r, tbl[i].s, tbl[i].f, tbl[i].v, tbl[i].rw, tbl[i].m2r,
                 tbl[i].alu, tbl[i].rd, tbl[i].dest);
            chk($sformatf("v%0d.we", i),   {31'd0, bus.RegWrite_Out},  {31'd0, tbl[i].e_we});
            chk($sformatf("v%0d.wa", i),   {27'd0, bus.WriteRegister}, {27'd0, tbl[i].e_wa});
            chk($sformatf("v%0d.wd", i),   bus.WriteData,              tbl[i].e_wd);
            chk($sformatf("v%0d.f2we", i), {31'd0, bus.Fwd2_RegWrite}, {31'd0, tbl[i].e_f2we});
            chk($sformatf("v%0d.f2a", i),  {27'd0, bus.Fwd2_Addr},     {27'd0, tbl[i].e_f2a});
            chk($sformatf("v%0d.f2d", i),  bus.Fwd2_Data,              tbl[i].e_f2d);
`ifdef RETIRE_CNT_EN
            chk($sformatf("v%0d.rc", i),   bus.RetireCount,            tbl[i].e_rc);
`endif
        end

        // Write suppressed inside the reset cycle, before reset takes effect
        step(0, 0, 0, 1, 1, 0, 32'hAB, 32'h0, 5'd9);
        @(negedge Clk);
        Rst = 1'b1;
        #1;
        chk("rst_cycle.we", {31'd0, bus.RegWrite_Out}, 32'd0);
        model_edge(1, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge Clk);
        #1;
        check_model("post_rst");

        for (int i = 0; i < 400; i++) begin
            logic        r, s, f, v, rw, m2r;
            logic [4:0]  d;
            r   = ($urandom_range(0, 49) == 0);
            s   = ($urandom_range(0, 3) == 0);
            f   = ($urandom_range(0, 9) == 0);
            v   = ($urandom_range(0, 9) < 7);
            rw  = ($urandom_range(0, 3) != 0);
            m2r = $urandom_range(0, 1);
            d   = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            step(r, s, f, v, rw, m2r, $urandom, $urandom, d);
            check_model($sformatf("rnd%0d", i));
        end

`ifdef RETIRE_CNT_EN
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 32'h5, 32'h0, 5'd4);
        force dut.retire_cnt_q = 32'hFFFFFFFF;
        #1;
        release dut.retire_cnt_q;
        m_rc = 32'hFFFFFFFF;
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("wrap.rc", bus.RetireCount, 32'h0);
        check_model("wrap");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
